freq_ratio_detector: RTL and testbench
======================================

FREQ_RATIO_DETECTOR -- requirements
Module: freq_ratio_detector

Interface
REQ-001 Parameter MAX_PERIOD, default 16, largest accepted div_clk period in clk cycles.
REQ-002 Parameter TIMEOUT, default 32, clk cycles without a div_clk rising edge before lock is declared lost.
REQ-003 clk  input  1  system clock; the divided clock is generated from this clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 div_clk  input  1  divided clock under measurement (divide-by-N, N = 2..16).
REQ-006 err_clr  input  1  one-cycle pulse; clears err_range and err_timeout.
REQ-007 ratio  output  4  measured N minus 1, matching the divider's modulus-minus-one encoding.
REQ-008 high_cnt  output  5  sampled high time of the last period, in clk cycles.
REQ-009 low_cnt  output  5  sampled low time of the last period, in clk cycles.
REQ-010 ratio_stb  output  1  one-cycle pulse on each new valid period measurement.
REQ-011 locked  output  1  level; two consecutive equal valid periods have been measured.
REQ-012 duty_ok  output  1  |high_cnt - low_cnt| <= 1 for the last period.
REQ-013 err_range  output  1  sticky; a period < 2 or > MAX_PERIOD was seen.
REQ-014 err_timeout  output  1  sticky; TIMEOUT was reached.

Function
REQ-015 div_clk shall pass through a 2-flop sampler; a rise is detected when stage2=1 and stage3=0.
REQ-016 A 5-bit period counter shall load 1 on rise detect, otherwise increment, saturating at 31; the high and low counters shall count sampled-high and sampled-low cycles in the same way.
REQ-017 The measured period shall be the counter value on the cycle of the rise detect.
REQ-018 FSM states shall be IDLE, ACQUIRE and LOCKED.
REQ-019 IDLE, on the first rise detect: go to ACQUIRE with no stored period.
REQ-020 ACQUIRE/LOCKED, on a rise with period in [2, MAX_PERIOD]: update ratio, high_cnt and low_cnt, and pulse ratio_stb on the next cycle.
REQ-021 In ACQUIRE, when the new period equals the stored period: go to LOCKED; otherwise store the period and remain in ACQUIRE.
REQ-022 In LOCKED, when the new period differs from the stored period: go to ACQUIRE, store the new period, and deassert locked.
REQ-023 On a rise with period out of range: set err_range, go to IDLE, and assert no ratio_stb.
REQ-024 When the counter reaches TIMEOUT with no rise detect: set err_timeout and go to IDLE; the first rise after this restarts acquisition.
REQ-025 locked shall be 1 only in LOCKED; ratio, high_cnt and low_cnt shall hold their last values in other states.
REQ-026 ratio shall be period-1, truncated to 4 bits; the result is exact for periods 2..16.
REQ-027 If err_clr coincides with a new error event, the set shall win.
REQ-028 duty_ok shall be registered with ratio_stb; for odd N the high/low split may be floor/ceil in either order.

Reset
REQ-029 On reset_n=0, asynchronously: state=IDLE; sampler flops, counters, ratio, high_cnt, low_cnt=0; ratio_stb, locked, duty_ok, err_range, err_timeout=0.
REQ-030 Reset asserted mid-lock shall drop locked immediately; relock shall need three rise detects after release.

Structure
REQ-031 A shared package shall hold the FSM state encoding, the MAX_PERIOD and TIMEOUT defaults, and the counter width (5).
REQ-032 The sampler and edge detector shall be one sub-module, edge_sampler, with outputs level and rise.
REQ-033 Total RTL shall be approximately 150-250 lines, with no latches and no negedge logic.

Verification
REQ-034 Divider at N=5 (clk period 10 ns), reset released at 5 ns -> ratio=4, high_cnt+low_cnt=5, duty_ok=1, locked=1 after the third rise.
REQ-035 Ratio change from N=5 to N=3 while locked -> locked drops on the first 3-cycle period, ratio_stb carries ratio=2, locked returns on the next equal period.
REQ-036 Minimum ratio N=2 -> ratio=1, high_cnt=low_cnt=1, locked=1; N=16 -> ratio=15, no error.
REQ-037 div_clk held high after lock -> err_timeout=1 and locked=0 exactly TIMEOUT (32) cycles after the last rise; err_clr then clears the flag.
REQ-038 Period of 20 cycles -> err_range=1, state IDLE, no ratio_stb, ratio unchanged.
REQ-039 reset_n pulsed low while locked -> all outputs 0 within the same cycle; relock on the third rise after release.

Source files
------------

// File: rtl/freq_ratio_detector_pkg.sv
// Shared types and defaults for the divided-clock ratio detector.
package freq_ratio_detector_pkg;

  localparam int CNT_W          = 5;
  localparam int RATIO_W        = 4;
  localparam int DEF_MAX_PERIOD = 16;
  localparam int DEF_TIMEOUT    = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/freq_ratio_detector_if.sv
// Measurement bus between the divided-clock source/consumer and the detector.
interface freq_ratio_detector_if;
  import freq_ratio_detector_pkg::*;

  logic               div_clk;
  logic               err_clr;
  logic [RATIO_W-1:0] ratio;
  logic [CNT_W-1:0]   high_cnt;
  logic [CNT_W-1:0]   low_cnt;
  logic               ratio_stb;
  logic               locked;
  logic               duty_ok;
  logic               err_range;
  logic               err_timeout;

  modport master (
    output div_clk, err_clr,
    input  ratio, high_cnt, low_cnt, ratio_stb, locked, duty_ok, err_range, err_timeout
  );

  modport slave (
    input  div_clk, err_clr,
    output ratio, high_cnt, low_cnt, ratio_stb, locked, duty_ok, err_range, err_timeout
  );

endinterface

// File: rtl/freq_ratio_detector_edge_sampler.sv
// Two-flop sampler for div_clk plus a history flop for rising-edge detection.
module edge_sampler (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic stage1, stage2, stage3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage1 <= 1'b0;
      stage2 <= 1'b0;
      stage3 <= 1'b0;
    end else begin
      stage1 <= din;
      stage2 <= stage1;
      stage3 <= stage2;
    end
  end

  assign level = stage2;
  assign rise  = stage2 & ~stage3;

endmodule

// File: rtl/freq_ratio_detector.sv
// Measures the period and duty of a clk-derived divided clock and tracks lock.
//   state      | meaning
//   ST_IDLE    | waiting for the first rise; no period reference
//   ST_ACQUIRE | measuring; stored period awaits a matching successor
//   ST_LOCKED  | two consecutive equal valid periods seen
module freq_ratio_detector
  import freq_ratio_detector_pkg::*;
#(
  parameter int MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic                  clk,
  input logic                  reset_n,
  freq_ratio_detector_if.slave bus
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t             state;
  logic               level, rise;
  logic [CNT_W-1:0]   period_cnt, high_acc, low_acc, stored, diff;
  logic [TMR_W-1:0]   tmr;
  logic               in_range, duty_now;
  logic [RATIO_W-1:0] ratio_q;
  logic [CNT_W-1:0]   high_q, low_q;
  logic               stb_q, locked_q, duty_q, err_range_q, err_timeout_q;

  edge_sampler u_sampler (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (bus.div_clk),
    .level   (level),
    .rise    (rise)
  );

  // On a rise the current cycle is already high, hence high_acc restarts at 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
      high_acc   <= '0;
      low_acc    <= '0;
      tmr        <= '0;
    end else if (rise) begin
      period_cnt <= CNT_W'(1);
      high_acc   <= CNT_W'(1);
      low_acc    <= '0;
      tmr        <= TMR_W'(TIMEOUT - 1);
    end else begin
      period_cnt <= sat_inc(period_cnt);
      if (level) high_acc <= sat_inc(high_acc);
      else       low_acc  <= sat_inc(low_acc);
      if (tmr != '0) tmr <= tmr - TMR_W'(1);
    end
  end

  assign in_range = (period_cnt >= CNT_W'(2)) && (period_cnt <= CNT_W'(MAX_PERIOD));
  assign diff     = (high_acc > low_acc) ? (high_acc - low_acc) : (low_acc - high_acc);
  assign duty_now = (diff <= CNT_W'(1));

  // Error sets are written after the clear so a coincident event wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      stored        <= '0;
      ratio_q       <= '0;
      high_q        <= '0;
      low_q         <= '0;
      stb_q         <= 1'b0;
      locked_q      <= 1'b0;
      duty_q        <= 1'b0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      if (bus.err_clr) begin
        err_range_q   <= 1'b0;
        err_timeout_q <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state  <= ST_ACQUIRE;
            stored <= '0;
          end
        end
        ST_ACQUIRE, ST_LOCKED: begin
          if (rise) begin
            if (!in_range) begin
              err_range_q <= 1'b1;
              locked_q    <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              ratio_q <= RATIO_W'(period_cnt - CNT_W'(1));
              high_q  <= high_acc;
              low_q   <= low_acc;
              duty_q  <= duty_now;
              stb_q   <= 1'b1;
              if (state == ST_ACQUIRE) begin
                if (period_cnt == stored) begin
                  state    <= ST_LOCKED;
                  locked_q <= 1'b1;
                end else begin
                  stored <= period_cnt;
                end
              end else if (period_cnt != stored) begin
                state    <= ST_ACQUIRE;
                stored   <= period_cnt;
                locked_q <= 1'b0;
              end
            end
          end else if (tmr == '0) begin
            err_timeout_q <= 1'b1;
            locked_q      <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ratio       = ratio_q;
  assign bus.high_cnt    = high_q;
  assign bus.low_cnt     = low_q;
  assign bus.ratio_stb   = stb_q;
  assign bus.locked      = locked_q;
  assign bus.duty_ok     = duty_q;
  assign bus.err_range   = err_range_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_freq_ratio_detector.sv
// Directed bench: a background divider model drives div_clk, tasks check each scenario.
module tb_freq_ratio_detector;
  import freq_ratio_detector_pkg::*;

  logic clk     = 1'b1;
  logic reset_n = 1'b1;
  int   total   = 0;
  int   bad     = 0;

  int   gen_n    = 5;
  int   gen_hi   = 3;
  logic gen_en   = 1'b0;
  logic gen_hold = 1'b0;

  int log_ratio[$], log_locked[$], log_high[$], log_low[$], log_duty[$];

  freq_ratio_detector_if bus();

  freq_ratio_detector dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Divider model: each period starts with its high phase, so every period boundary is a rise.
  initial begin
    int n, h;
    bus.div_clk = 1'b0;
    forever begin
      if (gen_en) begin
        n = gen_n;
        h = gen_hi;
        for (int i = 0; i < n; i++) begin
          @(posedge clk); #1;
          bus.div_clk = (i < h);
        end
      end else begin
        @(posedge clk); #1;
        bus.div_clk = gen_hold;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && bus.ratio_stb) begin
      log_ratio.push_back(int'(bus.ratio));
      log_locked.push_back(int'(bus.locked));
      log_high.push_back(int'(bus.high_cnt));
      log_low.push_back(int'(bus.low_cnt));
      log_duty.push_back(int'(bus.duty_ok));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic sync_stb(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(posedge clk); #1;
      if (bus.ratio_stb) ok = 1'b1;
    end
  endtask

  task automatic wait_stb(input int k, output logic ok);
    int target;
    target = log_ratio.size() + k;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk); #1;
      if (log_ratio.size() >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_locked(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(posedge clk); #1;
      if (bus.locked) ok = 1'b1;
    end
  endtask

  // Changes the divider, then locates the first measurement of the new ratio in the log.
  task automatic switch_mode(input int n, input int hi, output int j, output logic ok);
    logic s, w;
    int   idx;
    sync_stb(s);
    gen_n  = n;
    gen_hi = hi;
    @(negedge clk); #1;
    idx = log_ratio.size();
    wait_stb(5, w);
    ok = s && w;
    j  = -1;
    for (int i = idx; i < log_ratio.size(); i++)
      if (j < 0 && log_ratio[i] == n - 1) j = i;
    if (j < 1 || j + 1 >= log_ratio.size()) ok = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    total++;
    if ({bus.ratio, bus.high_cnt, bus.low_cnt, bus.ratio_stb, bus.locked, bus.duty_ok,
         bus.err_range, bus.err_timeout} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ratio=%0d high=%0d low=%0d stb=%0b locked=%0b duty=%0b er=%0b et=%0b, all required 0",
               bus.ratio, bus.high_cnt, bus.low_cnt, bus.ratio_stb, bus.locked, bus.duty_ok,
               bus.err_range, bus.err_timeout);
    end
    #2 reset_n = 1'b1;
    #2;
    total++;
    if (bus.locked !== 1'b0 || bus.ratio !== 4'd0) begin
      bad++;
      $display("FAIL reset_release: locked=%0b ratio=%0d, required 0 and 0", bus.locked, bus.ratio);
    end
  endtask

  task automatic test_basic();
    logic ok;
    gen_n  = 5;
    gen_hi = 3;
    gen_en = 1'b1;
    wait_stb(2, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_stb: got %0d strobes, required 2", log_ratio.size());
    end else begin
      total++;
      if (log_ratio[0] !== 4 || log_locked[0] !== 0 || log_high[0] + log_low[0] !== 5) begin
        bad++;
        $display("FAIL basic_first: ratio=%0d locked=%0d high+low=%0d, required 4 0 5",
                 log_ratio[0], log_locked[0], log_high[0] + log_low[0]);
      end
      total++;
      if (log_ratio[1] !== 4 || log_locked[1] !== 1 || log_high[1] !== 3 || log_low[1] !== 2
          || log_duty[1] !== 1) begin
        bad++;
        $display("FAIL basic_third_rise: ratio=%0d locked=%0d high=%0d low=%0d duty=%0d, required 4 1 3 2 1",
                 log_ratio[1], log_locked[1], log_high[1], log_low[1], log_duty[1]);
      end
    end
  endtask

  task automatic test_ratio_change();
    int   j;
    logic ok;
    switch_mode(3, 2, j, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL change_seq: ratio 2 measurement pair not observed");
    end else begin
      total++;
      if (log_locked[j-1] !== 1 || log_locked[j] !== 0) begin
        bad++;
        $display("FAIL change_drop: locked before=%0d at first 3-period=%0d, required 1 then 0",
                 log_locked[j-1], log_locked[j]);
      end
      total++;
      if (log_ratio[j+1] !== 2 || log_locked[j+1] !== 1) begin
        bad++;
        $display("FAIL change_relock: ratio=%0d locked=%0d, required 2 1", log_ratio[j+1], log_locked[j+1]);
      end
    end
  endtask

  task automatic test_min_ratio();
    int   j;
    logic ok;
    switch_mode(2, 1, j, ok);
    total++;
    if (!ok || log_locked[j] !== 0 || log_locked[j+1] !== 1) begin
      bad++;
      $display("FAIL min_seq: relock at N=2 not observed (ok=%0b)", ok);
    end
    total++;
    if (bus.ratio !== 4'd1 || bus.high_cnt !== 5'd1 || bus.low_cnt !== 5'd1 || bus.locked !== 1'b1
        || bus.duty_ok !== 1'b1) begin
      bad++;
      $display("FAIL min_values: ratio=%0d high=%0d low=%0d locked=%0b duty=%0b, required 1 1 1 1 1",
               bus.ratio, bus.high_cnt, bus.low_cnt, bus.locked, bus.duty_ok);
    end
  endtask

  task automatic test_max_ratio();
    int   j;
    logic ok;
    switch_mode(16, 8, j, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL max_seq: ratio 15 measurement pair not observed");
    end
    total++;
    if (bus.ratio !== 4'd15 || bus.high_cnt !== 5'd8 || bus.low_cnt !== 5'd8 || bus.locked !== 1'b1
        || bus.err_range !== 1'b0) begin
      bad++;
      $display("FAIL max_values: ratio=%0d high=%0d low=%0d locked=%0b err_range=%0b, required 15 8 8 1 0",
               bus.ratio, bus.high_cnt, bus.low_cnt, bus.locked, bus.err_range);
    end
  endtask

  task automatic test_duty();
    int   j;
    logic ok;
    switch_mode(6, 5, j, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL duty_seq: ratio 5 measurement pair not observed");
    end
    total++;
    if (bus.ratio !== 4'd5 || bus.high_cnt !== 5'd5 || bus.low_cnt !== 5'd1 || bus.duty_ok !== 1'b0
        || bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL duty_values: ratio=%0d high=%0d low=%0d duty=%0b locked=%0b, required 5 5 1 0 1",
               bus.ratio, bus.high_cnt, bus.low_cnt, bus.duty_ok, bus.locked);
    end
  endtask

  task automatic test_timeout();
    logic s;
    logic hit  = 1'b0;
    logic seen = 1'b0;
    int   cnt  = 0;
    sync_stb(s);
    gen_en   = 1'b0;
    gen_hold = 1'b1;
    // err_clr is pulsed on the very cycle the timeout fires; the flag must still set.
    for (int c = 0; c < 300 && !hit; c++) begin
      @(posedge clk); #1;
      if (bus.ratio_stb) begin
        cnt  = 0;
        seen = 1'b1;
      end else begin
        cnt++;
      end
      bus.err_clr = (seen && cnt == 31);
      if (bus.err_timeout) hit = 1'b1;
    end
    bus.err_clr = 1'b0;
    total++;
    if (!s || !hit || cnt !== 32) begin
      bad++;
      $display("FAIL timeout_delay: flag=%0b cycles after last strobe=%0d, required 1 and 32", hit, cnt);
    end
    total++;
    if (bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL timeout_unlock: locked=%0b, required 0", bus.locked);
    end
    @(posedge clk); #1 bus.err_clr = 1'b1;
    @(posedge clk); #1 bus.err_clr = 1'b0;
    total++;
    if (bus.err_timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: err_timeout=%0b, required 0", bus.err_timeout);
    end
  endtask

  task automatic test_range();
    logic ok, s, w;
    logic hit = 1'b0;
    int   idx;
    gen_n  = 5;
    gen_hi = 3;
    gen_en = 1'b1;
    wait_locked(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL range_prelock: locked=%0b, required 1", bus.locked);
    end
    sync_stb(s);
    gen_n  = 20;
    gen_hi = 10;
    @(negedge clk); #1;
    wait_stb(1, w);
    idx = log_ratio.size();
    for (int c = 0; c < 60 && !hit; c++) begin
      @(posedge clk); #1;
      if (bus.err_range) hit = 1'b1;
    end
    total++;
    if (!s || !w || !hit) begin
      bad++;
      $display("FAIL range_flag: err_range=%0b, required 1", hit);
    end
    total++;
    if (log_ratio.size() !== idx || bus.ratio !== 4'd4 || bus.high_cnt !== 5'd3 || bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL range_hold: extra strobes=%0d ratio=%0d high=%0d locked=%0b, required 0 4 3 0",
               log_ratio.size() - idx, bus.ratio, bus.high_cnt, bus.locked);
    end
    @(posedge clk); #1 bus.err_clr = 1'b1;
    @(posedge clk); #1 bus.err_clr = 1'b0;
    total++;
    if (bus.err_range !== 1'b0) begin
      bad++;
      $display("FAIL range_clear: err_range=%0b, required 0", bus.err_range);
    end
    gen_n  = 5;
    gen_hi = 3;
    wait_locked(ok);
    total++;
    if (!ok || bus.ratio !== 4'd4 || bus.err_range !== 1'b0) begin
      bad++;
      $display("FAIL range_recover: locked=%0b ratio=%0d err_range=%0b, required 1 4 0",
               bus.locked, bus.ratio, bus.err_range);
    end
  endtask

  task automatic test_reset_midlock();
    logic s, ok;
    int   idx;
    sync_stb(s);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (!s || {bus.ratio, bus.high_cnt, bus.low_cnt, bus.ratio_stb, bus.locked, bus.duty_ok,
               bus.err_range, bus.err_timeout} !== '0) begin
      bad++;
      $display("FAIL midlock_reset: ratio=%0d high=%0d low=%0d locked=%0b duty=%0b, all required 0",
               bus.ratio, bus.high_cnt, bus.low_cnt, bus.locked, bus.duty_ok);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    idx = log_ratio.size();
    wait_stb(2, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midlock_stb: strobes after release=%0d, required 2", log_ratio.size() - idx);
    end else begin
      total++;
      if (log_locked[idx] !== 0 || log_locked[idx+1] !== 1 || log_ratio[idx+1] !== 4) begin
        bad++;
        $display("FAIL midlock_relock: locked second=%0d third=%0d ratio=%0d, required 0 1 4",
                 log_locked[idx], log_locked[idx+1], log_ratio[idx+1]);
      end
    end
  endtask

  initial begin
    bus.err_clr = 1'b0;
    test_reset();
    test_basic();
    test_ratio_change();
    test_min_ratio();
    test_max_ratio();
    test_duty();
    test_timeout();
    test_range();
    test_reset_midlock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
